// File: rtl/sensor_responder_pkg.sv
// Shared constants for the polled UART sensor bus endpoint.
// FSM encodings, reserved frames and CRC polynomial.
package sensor_responder_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_TURN   = 3'd2;
    localparam logic [2:0] ST_SEND_D = 3'd3;
    localparam logic [2:0] ST_WAIT_D = 3'd4;
    localparam logic [2:0] ST_SEND_C = 3'd5;
    localparam logic [2:0] ST_WAIT_C = 3'd6;

    localparam logic [2:0] BROADCAST_ADDR = 3'd0;
    localparam logic [7:0] ALARM_DATA     = 8'hFF;
    localparam logic [7:0] ALARM_CRC      = 8'hA5;
    localparam logic [7:0] CRC_POLY       = 8'h07;

    localparam int UART_CLKS_PER_BIT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] crc;
    } reply_t;

endpackage

// File: rtl/sensor_responder_crc8.sv
// Combinational CRC-8 of one byte: init 0, MSB first, no reflection.
// Shared with the master-side frame check.
module crc8_gen
    import sensor_responder_pkg::*;
(
    input  logic [7:0] d,
    output logic [7:0] crc
);

    logic [7:0] w_c;

    always_comb begin
        w_c = d;
        for (int i = 0; i < 8; i++) begin
            if (w_c[7])
                w_c = {w_c[6:0], 1'b0} ^ CRC_POLY;
            else
                w_c = {w_c[6:0], 1'b0};
        end
        crc = w_c;
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART: transmitter with busy flag, receiver with sticky rdy.
// rdy stays set until rdy_clr; a new byte overwrites dout.
module uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rdy_clr,
    output logic       tx,
    output logic       tx_busy,
    output logic       rdy,
    output logic [7:0] dout
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

    logic       r_tx_busy;
    logic [9:0] r_tx_sh;
    logic [15:0] r_tx_clk;
    logic [3:0] r_tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy <= 1'b0;
            r_tx_sh   <= 10'h3FF;
            r_tx_clk  <= '0;
            r_tx_bit  <= '0;
        end else if (!r_tx_busy) begin
            if (wr_en) begin
                r_tx_busy <= 1'b1;
                r_tx_sh   <= {1'b1, din, 1'b0};
                r_tx_clk  <= '0;
                r_tx_bit  <= '0;
            end
        end else if (r_tx_clk == LAST) begin
            r_tx_clk <= '0;
            r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
            if (r_tx_bit == 4'd9)
                r_tx_busy <= 1'b0;
            else
                r_tx_bit <= r_tx_bit + 4'd1;
        end else begin
            r_tx_clk <= r_tx_clk + 16'd1;
        end
    end

    assign tx      = r_tx_busy ? r_tx_sh[0] : 1'b1;
    assign tx_busy = r_tx_busy;

    logic [1:0]  r_sync;
    logic        r_rx_act;
    logic [15:0] r_rx_clk;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;
    logic        r_rdy;
    logic [7:0]  r_dout;
    logic        w_rx;

    assign w_rx = r_sync[1];

    // bit 0 is the start-bit phase, 1..8 data, 9 stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b11;
            r_rx_act <= 1'b0;
            r_rx_clk <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
            r_rdy    <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_sync <= {r_sync[0], rx};
            if (rdy_clr)
                r_rdy <= 1'b0;
            if (!r_rx_act) begin
                if (!w_rx) begin
                    r_rx_act <= 1'b1;
                    r_rx_clk <= '0;
                    r_rx_bit <= '0;
                end
            end else if (r_rx_bit == 4'd0) begin
                if (r_rx_clk == HALF) begin
                    r_rx_clk <= '0;
                    if (w_rx)
                        r_rx_act <= 1'b0;
                    else
                        r_rx_bit <= 4'd1;
                end else begin
                    r_rx_clk <= r_rx_clk + 16'd1;
                end
            end else if (r_rx_clk == LAST) begin
                r_rx_clk <= '0;
                if (r_rx_bit == 4'd9) begin
                    r_rx_act <= 1'b0;
                    if (w_rx) begin
                        r_dout <= r_rx_sh;
                        r_rdy  <= 1'b1;
                    end
                end else begin
                    r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 4'd1;
                end
            end else begin
                r_rx_clk <= r_rx_clk + 16'd1;
            end
        end
    end

    assign rdy  = r_rdy;
    assign dout = r_dout;

endmodule

// File: rtl/sensor_responder.sv
// Sensor node endpoint: answers address-matched polls with data+CRC
// or the reserved alarm frame; address 0 clears the alarm latch.
module sensor_responder
    import sensor_responder_pkg::*;
#(
    parameter logic [2:0] SENSOR_ID  = 3'd1,
    parameter int         TURNAROUND = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] sample_data,
    input  logic       alarm_in,
    output logic       busy,
    output logic       alarm_pending,
    output logic [2:0] state
);

    logic [2:0] r_state;
    logic       r_busy;
    logic       r_alarm;
    logic       r_alarm_d;
    reply_t     r_reply;
    logic [7:0] r_cnt;
    logic       r_seen;

    logic       w_rdy;
    logic [7:0] w_dout;
    logic       w_tx_busy;
    logic       w_wr_en;
    logic       w_rdy_clr;
    logic [7:0] w_din;
    logic [7:0] w_crc;
    logic [2:0] w_addr;
    logic       w_match;
    logic       w_bcast;
    logic       w_rise;
    logic       w_unused_cmd;

    assign w_addr       = w_dout[2:0];
    assign w_unused_cmd = ^w_dout[7:3];
    assign w_match      = (w_addr == SENSOR_ID);
    assign w_rdy_clr    = (r_state == ST_DECODE);
    assign w_bcast      = w_rdy_clr && (w_addr == BROADCAST_ADDR);
    assign w_rise       = alarm_in & ~r_alarm_d;
    assign w_wr_en      = ((r_state == ST_SEND_D) || (r_state == ST_SEND_C))
                          && !w_tx_busy;
    assign w_din        = (r_state == ST_SEND_C) ? r_reply.crc : r_reply.data;

    crc8_gen u_crc (
        .d   (sample_data),
        .crc (w_crc)
    );

    uart #(
        .CLKS_PER_BIT (UART_CLKS_PER_BIT)
    ) u_uart (
        .clk     (clock),
        .rst_n   (resetn),
        .rx      (rx),
        .wr_en   (w_wr_en),
        .din     (w_din),
        .rdy_clr (w_rdy_clr),
        .tx      (tx),
        .tx_busy (w_tx_busy),
        .rdy     (w_rdy),
        .dout    (w_dout)
    );

    // a new rising edge beats a same-cycle broadcast clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_alarm_d <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_alarm_d <= alarm_in;
            if (w_rise)
                r_alarm <= 1'b1;
            else if (w_bcast)
                r_alarm <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_reply <= '0;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rdy)
                        r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_match) begin
                        r_reply.data <= r_alarm ? ALARM_DATA : sample_data;
                        r_reply.crc  <= r_alarm ? ALARM_CRC : w_crc;
                        r_cnt        <= 8'(TURNAROUND);
                        r_busy       <= 1'b1;
                        r_state      <= ST_TURN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_TURN: begin
                    if (r_cnt <= 8'd1)
                        r_state <= ST_SEND_D;
                    else
                        r_cnt <= r_cnt - 8'd1;
                end
                ST_SEND_D: begin
                    if (!w_tx_busy) begin
                        r_seen  <= 1'b0;
                        r_state <= ST_WAIT_D;
                    end
                end
                ST_WAIT_D: begin
                    if (w_tx_busy)
                        r_seen <= 1'b1;
                    else if (r_seen)
                        r_state <= ST_SEND_C;
                end
                ST_SEND_C: begin
                    if (!w_tx_busy) begin
                        r_seen  <= 1'b0;
                        r_state <= ST_WAIT_C;
                    end
                end
                ST_WAIT_C: begin
                    if (w_tx_busy) begin
                        r_seen <= 1'b1;
                    end else if (r_seen) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign alarm_pending = r_alarm;
    assign state         = r_state;

endmodule
